mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-master request arbiter that sits directly upstream of ext_sram's request interface.
//  - Master D (data load/store, read+write) and master I (instruction fetch, read-only)
//    share the single external SRAM.
//  - Accepts one transaction at a time, drives the SRAM handshake, and routes the result back.
//  - Fixed priority D > I, with a starvation guard so fetch always makes progress.
// PARAMETERS
//  STARVE_MAX  4  consecutive D grants allowed while I is pending before I is forced; >=1
// PORTS
//  clk        in   1   system clock; all state on posedge
//  reset      in   1   synchronous, active-high
//  d_valid    in   1   D request; held with fields until d_ready
//  d_rw       in   1   D direction, 1 = write
//  d_addr     in   32  D byte address
//  d_dtw      in   32  D write data
//  d_ready    out  1   1-cycle completion pulse to D
//  d_dtr      out  32  D read data, valid while d_ready=1
//  i_valid    in   1   I request; held with i_addr until i_ready
//  i_addr     in   32  I byte address
//  i_ready    out  1   1-cycle completion pulse to I
//  i_dtr      out  32  I read data, valid while i_ready=1
//  mem_valid  out  1   to ext_sram valid; exactly 1-cycle pulse per transaction
//  mem_rw     out  1   to ext_sram rw
//  mem_addr   out  32  to ext_sram addri
//  mem_dtw    out  32  to ext_sram dtw
//  mem_ready  in   1   from ext_sram ready; 1-cycle completion pulse
//  mem_dtr    in   32  from ext_sram dtr; sampled when mem_ready=1
//  busy       out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, all outputs 0, starvation counter=0.
//  Reset mid-transaction: return to IDLE with no ready pulse; ext_sram shares the reset.
//  States:
//  - IDLE: sample d_valid/i_valid at posedge.
//    - Neither pending: stay in IDLE.
//    - Otherwise grant per rule below, latch mem_rw/mem_addr/mem_dtw and grant id,
//      then go to ISSUE.
//    - mem_rw is forced to 0 for an I grant.
//  - ISSUE: mem_valid=1 for this one cycle only; go to WAIT.
//  - WAIT: mem_valid=0; wait for mem_ready.
//    - On mem_ready: register mem_dtr into the granted master's dtr; go to RESP.
//    - Wait length is unbounded.
//  - RESP: ready=1 for the granted master only, one cycle; the other ready stays 0.
//    Go to IDLE.
//  Output stability:
//  - mem_rw, mem_addr, mem_dtw are held constant from ISSUE through RESP;
//    ext_sram reads rw/dtw after acceptance.
//  - d_dtr/i_dtr hold their last value outside RESP.
//  Grant rule:
//  - Only d_valid set: grant D. Only i_valid set: grant I.
//  - Both set: grant D unless starve_cnt == STARVE_MAX, then grant I.
//  Starvation counter (width $clog2(STARVE_MAX+1)):
//  - Increments on a D grant made while i_valid=1.
//  - Clears on any I grant, or on a D grant with i_valid=0.
//  - Saturates at STARVE_MAX.
//  Latency:
//  - Request sampled in IDLE at edge N: mem_valid in cycle N+1.
//  - mem_ready in cycle M: master ready/dtr in cycle M+1.
//  - Next IDLE sample at cycle M+2.
//  - Minimum master-to-master turnaround is 1 IDLE cycle; no back-to-back mem_valid.
//  Request sampling:
//  - Requests are sampled only in IDLE; a request arriving in ISSUE/WAIT/RESP waits.
//  - Deasserting valid before ready is a protocol violation: the transaction
//    completes anyway and the ready pulse is still issued.
//  - A stray mem_ready in IDLE or ISSUE is ignored.
// STRUCTURE
//  Shared package hs32_mem_pkg:
//  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
//  - master id constants (MST_D=1'b0, MST_I=1'b1)
//  - request bundle width constants
//  One sub-module, mem_arb_pick: combinational grant select plus the starvation
//  counter update. Inputs: d_valid, i_valid, starve_cnt. Outputs: grant, next count.
//  FSM, request latches and response routing stay in mem_arbiter.
// TESTING
//  1. D write 0x0000_1002 / 0xDEADBEEF, I idle.
//     -> mem_valid pulses 1 cycle with mem_rw=1 and that address/data held through RESP.
//     -> d_ready 1 cycle after mem_ready; i_ready never asserts.
//  2. I read 0x0000_0100, model returns 0x1234_5678 after 6 cycles.
//     -> i_dtr=0x12345678 with i_ready 1 cycle after mem_ready; mem_rw=0.
//  3. d_valid and i_valid held high continuously, STARVE_MAX=4.
//     -> grant order D,D,D,D,I,D,D,D,D,I...
//  4. Both pending, I dropped after 2 D grants, then re-raised.
//     -> counter clears and I waits 4 further D grants.
//  5. reset asserted in WAIT.
//     -> next cycle: IDLE, busy=0, no ready pulse; a pending D is re-granted after reset.
//  6. mem_ready asserted in IDLE with no request.
//     -> no ready pulse, state stays IDLE, mem_valid stays 0.

Source files
------------

// File: rtl/hs32_mem_pkg.sv
// Shared definitions for the hs32 external-memory path: arbiter state encoding,
// master ids and the request bundle latched toward ext_sram.
package hs32_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic MST_D = 1'b0;
    localparam logic MST_I = 1'b1;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dtw;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the two-master arbiter: data master wins unless the
// fetch master has been passed over STARVE_MAX times in a row.
module mem_arb_pick
    import hs32_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             d_valid,
    input  logic             i_valid,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant,
    output logic [CNT_W-1:0] cnt_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    // With neither request pending the outputs are don't-care; the caller only
    // commits them when at least one master is asking.
    always_comb begin
        grant    = MST_I;
        cnt_next = '0;
        if (d_valid && !(i_valid && (starve_cnt == CNT_MAX))) begin
            grant = MST_D;
            if (i_valid) begin
                cnt_next = (starve_cnt == CNT_MAX) ? CNT_MAX : starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (data / instruction-fetch) arbiter in front of ext_sram. One
// transaction in flight; request fields are held from issue until the response.
module mem_arbiter
    import hs32_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dtw,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_dtr,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_dtr,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dtw,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_dtr,
    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_grant;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              w_grant;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_req;
    logic              w_take;
    mem_req_t          r_req;
    logic [DATA_W-1:0] r_d_dtr;
    logic [DATA_W-1:0] r_i_dtr;

    assign w_req  = d_valid | i_valid;
    assign w_take = (r_state == ST_IDLE) && w_req;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .d_valid    (d_valid),
        .i_valid    (i_valid),
        .starve_cnt (r_starve_cnt),
        .grant      (w_grant),
        .cnt_next   (w_cnt_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_req) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT:  if (mem_ready) w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Request latch and response capture; mem_ready outside WAIT is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= MST_D;
            r_starve_cnt <= '0;
            r_req        <= '0;
            r_d_dtr      <= '0;
            r_i_dtr      <= '0;
        end else begin
            if (w_take) begin
                r_grant      <= w_grant;
                r_starve_cnt <= w_cnt_next;
                if (w_grant == MST_D) begin
                    r_req.rw   <= d_rw;
                    r_req.addr <= d_addr;
                    r_req.dtw  <= d_dtw;
                end else begin
                    r_req.rw   <= 1'b0;
                    r_req.addr <= i_addr;
                    r_req.dtw  <= '0;
                end
            end
            if ((r_state == ST_WAIT) && mem_ready) begin
                if (r_grant == MST_D) begin
                    r_d_dtr <= mem_dtr;
                end else begin
                    r_i_dtr <= mem_dtr;
                end
            end
        end
    end

    always_comb begin
        mem_valid = (r_state == ST_ISSUE);
        busy      = (r_state != ST_IDLE);
        d_ready   = (r_state == ST_RESP) && (r_grant == MST_D);
        i_ready   = (r_state == ST_RESP) && (r_grant == MST_I);
    end

    assign mem_rw   = r_req.rw;
    assign mem_addr = r_req.addr;
    assign mem_dtw  = r_req.dtw;
    assign d_dtr    = r_d_dtr;
    assign i_dtr    = r_i_dtr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: an SRAM responder plus a spec-level model
// of grant order, request fields and returned data.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid, d_rw, d_ready;
    logic [31:0] d_addr, d_dtw, d_dtr;
    logic        i_valid, i_ready;
    logic [31:0] i_addr, i_dtr;
    logic        mem_valid, mem_rw, mem_ready, busy;
    logic [31:0] mem_addr, mem_dtw, mem_dtr;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_valid   (d_valid),
        .d_rw      (d_rw),
        .d_addr    (d_addr),
        .d_dtw     (d_dtw),
        .d_ready   (d_ready),
        .d_dtr     (d_dtr),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_dtr     (i_dtr),
        .mem_valid (mem_valid),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_dtw   (mem_dtw),
        .mem_ready (mem_ready),
        .mem_dtr   (mem_dtr),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int          model_cnt = 0;
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] last_d = 32'h0;
    logic [31:0] last_i = 32'h0;

    // gi = 1 means the fetch master wins
    task automatic model_grant(input bit dv, input bit iv, output bit gi);
        if (dv && !(iv && model_cnt >= STARVE_MAX)) begin
            gi = 1'b0;
            if (iv) model_cnt = (model_cnt + 1 > STARVE_MAX) ? STARVE_MAX : model_cnt + 1;
            else    model_cnt = 0;
        end else begin
            gi = 1'b1;
            model_cnt = 0;
        end
    endtask

    // Called at an IDLE negedge with at least one request pending; returns at
    // the following IDLE negedge.
    task automatic do_txn(input int lat, output bit gi);
        int          waited = 0;
        bit          exp_rw;
        logic [31:0] exp_addr, exp_dtw, rsp;
        gi = 1'b0;
        while (mem_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_latency", waited, 1);
        if (mem_valid !== 1'b1) return;
        model_grant(d_valid, i_valid, gi);
        exp_rw   = gi ? 1'b0 : d_rw;
        exp_addr = gi ? i_addr : d_addr;
        exp_dtw  = d_dtw;
        check("issue_rw", mem_rw, exp_rw);
        check("issue_addr", mem_addr, exp_addr);
        if (!gi) check("issue_dtw", mem_dtw, exp_dtw);
        check("issue_busy", busy, 1);
        @(negedge clk);
        check("mv_pulse", mem_valid, 0);
        repeat (lat) begin
            @(negedge clk);
            check("wait_mv", mem_valid, 0);
            check("wait_rdy", {d_ready, i_ready}, 0);
            check("wait_addr_hold", mem_addr, exp_addr);
        end
        if (exp_rw) rsp = $urandom;
        else        rsp = mem_model.exists(exp_addr) ? mem_model[exp_addr] : 32'h0;
        mem_ready = 1'b1;
        mem_dtr   = rsp;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_dtr   = $urandom;
        check("resp_d_ready", d_ready, !gi);
        check("resp_i_ready", i_ready, gi);
        check("resp_rw_hold", mem_rw, exp_rw);
        check("resp_addr_hold", mem_addr, exp_addr);
        if (!gi) check("resp_dtw_hold", mem_dtw, exp_dtw);
        if (gi) begin
            check("resp_i_dtr", i_dtr, rsp);
            check("keep_d_dtr", d_dtr, last_d);
            last_i = rsp;
        end else begin
            check("resp_d_dtr", d_dtr, rsp);
            check("keep_i_dtr", i_dtr, last_i);
            last_d = rsp;
        end
        if (exp_rw) mem_model[exp_addr] = exp_dtw;
        @(negedge clk);
        check("post_rdy", {d_ready, i_ready}, 0);
        check("post_busy", busy, 0);
    endtask

    task automatic new_d();
        d_rw   = 1'($urandom_range(0, 1));
        d_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        d_dtw  = $urandom;
    endtask

    task automatic new_i();
        i_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gi;
        int nd;
        reset = 1'b1;
        d_valid = 0; d_rw = 0; d_addr = 0; d_dtw = 0;
        i_valid = 0; i_addr = 0;
        mem_ready = 0; mem_dtr = 0;
        repeat (3) @(negedge clk);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", {d_ready, i_ready}, 0);
        check("rst_mem_fields", {31'h0, mem_rw} | mem_addr | mem_dtw, 0);
        check("rst_dtr", d_dtr | i_dtr, 0);
        reset = 1'b0;

        // D write, I idle
        d_valid = 1; d_rw = 1; d_addr = 32'h0000_1002; d_dtw = 32'hDEAD_BEEF;
        do_txn(3, gi);
        check("t1_grant", gi, 0);
        d_valid = 0;

        // I read returning a preloaded word after 6 wait cycles
        mem_model[32'h0000_0100] = 32'h1234_5678;
        i_valid = 1; i_addr = 32'h0000_0100;
        do_txn(6, gi);
        check("t2_grant", gi, 1);
        check("t2_i_dtr", last_i, 32'h1234_5678);
        i_valid = 0;

        // Both held high: D,D,D,D,I repeating
        d_valid = 1; i_valid = 1; new_d(); new_i();
        for (int k = 0; k < 10; k++) begin
            do_txn($urandom_range(0, 3), gi);
            check("t3_order", gi, (k % 5 == 4));
            if (gi) new_i(); else new_d();
        end

        // I dropped after 2 D grants, then re-raised: counter restarts
        do_txn(1, gi); check("t4_d1", gi, 0); new_d();
        do_txn(1, gi); check("t4_d2", gi, 0); new_d();
        i_valid = 0;
        do_txn(1, gi); check("t4_d3", gi, 0); new_d();
        i_valid = 1;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            do_txn(0, gi);
            if (gi) break;
            nd++;
            new_d();
        end
        check("t4_d_before_i", nd, 4);
        d_valid = 0; i_valid = 0;

        // Stray mem_ready in IDLE
        mem_ready = 1; mem_dtr = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ready = 0;
        repeat (3) begin
            @(negedge clk);
            check("t6_busy", busy, 0);
            check("t6_mem_valid", mem_valid, 0);
            check("t6_ready", {d_ready, i_ready}, 0);
        end
        check("t6_d_dtr", d_dtr, last_d);
        check("t6_i_dtr", i_dtr, last_i);

        // Reset while waiting on the SRAM; the D request is re-granted afterwards
        d_valid = 1; new_d();
        @(negedge clk);
        check("t5_issue", mem_valid, 1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_ready", {d_ready, i_ready}, 0);
        check("t5_mem_valid", mem_valid, 0);
        check("t5_d_dtr", d_dtr, 0);
        reset = 0;
        model_cnt = 0; last_d = 0; last_i = 0;
        do_txn(2, gi);
        check("t5_regrant", gi, 0);
        d_valid = 0;

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            if (!d_valid && $urandom_range(0, 2) != 0) begin d_valid = 1; new_d(); end
            if (!i_valid && $urandom_range(0, 2) != 0) begin i_valid = 1; new_i(); end
            if (!d_valid && !i_valid) begin
                @(negedge clk);
                check("rnd_idle", busy, 0);
            end else begin
                do_txn($urandom_range(0, 5), gi);
                if (gi) begin i_valid = 1'($urandom_range(0, 1)); new_i(); end
                else    begin d_valid = 1'($urandom_range(0, 1)); new_d(); end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
